shift_right_seq: RTL and testbench

Iterative 16-bit right shifter with valid/ready handshakes on both sides. It is the right-shift counterpart to the datapath's combinational left shifter. It accepts an operand, a shift amount and a logical/arithmetic mode. It then shifts one bit position per clock and presents the result until the consumer takes it. The block sits between an operand producer and a result consumer, and trades latency for a single-bit shift stage instead of a full barrel network.

---
 rtl/shift_right_seq.sv | 129 ++++++++++++
 tb/tb_shift_right_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// shift_right_seq
// ---------------
// Iterative right shifter. An operand is captured in IDLE, shifted one bit
// per clock in SHIFT (zero fill or sign fill), and held in DONE until the
// consumer takes it. A single one-bit shift stage is used in place of a
// barrel network, so latency equals the clamped shift amount.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The sender holds its payload stable while
// valid is high and ready is low. in_ready and out_valid are decoded from
// the registered state only. They never depend on in_valid or out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   producer presents an operand
//   in_ready   block can accept an operand (IDLE, not in reset)
//   data_in    operand
//   shift_amt  unsigned shift distance; values >= WIDTH clamp to WIDTH
//   arith      1 = sign fill, 0 = zero fill
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   data_out   result, 0 whenever out_valid is low
//   busy       operation in flight (SHIFT or DONE)
//   state_dbg  current FSM state encoding, for observation only
module shift_right_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // The counter must be able to hold WIDTH itself, not only WIDTH-1.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] cnt;
  logic             fill;

  logic             accept;
  logic [CNT_W-1:0] amt_clamped;

  // Compare the full-width amount so that large values clamp rather than
  // wrapping into a small count after truncation.
  always_comb begin
    amt_clamped = CNT_W'(WIDTH);
    if (shift_amt < AMT_W'(WIDTH)) begin
      amt_clamped = CNT_W'(shift_amt);
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (amt_clamped != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (cnt == CNT_W'(1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      work  <= '0;
      cnt   <= '0;
      fill  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (accept) begin
            work <= data_in;
            cnt  <= amt_clamped;
            fill <= arith & data_in[WIDTH-1];
          end
        end
        S_SHIFT: begin
          work <= {fill, work[WIDTH-1:1]};
          cnt  <= cnt - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // in_ready is also gated by rst so it reads low during the reset cycle,
  // even once the state register has already returned to IDLE.
  assign in_ready  = (state == S_IDLE) & ~rst;
  assign out_valid = (state == S_DONE);
  assign data_out  = out_valid ? work : '0;
  assign busy      = (state == S_SHIFT) | (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_right_seq.sv
// Testbench for shift_right_seq: directed cases followed by randomized
// operations, with results compared against a reference model built from
// plain shift arithmetic.
module tb_shift_right_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic [15:0] shift_amt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks;
  int errors;
  int last_accept_waits;
  logic [15:0] exp_q[$];

  shift_right_seq #(.WIDTH(16), .AMT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .shift_amt (shift_amt),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: amounts of 16 or more saturate to all fill bits.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [15:0] amt, input logic ar);
    logic signed [15:0] sd;
    sd = d;
    if (amt >= 16) return (ar && d[15]) ? 16'hFFFF : 16'h0000;
    if (ar) return 16'(sd >>> amt);
    return d >> amt;
  endfunction

  function automatic int clamp_amt(input logic [15:0] amt);
    return (amt >= 16) ? 16 : int'(amt);
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: optional idle gap, acceptance, latency wait,
  // a stall of 'stall' cycles with out_ready low, then the output handshake.
  // With poke set, the stall cycles present 0xAAAA on the input side.
  task automatic do_op(input logic [15:0] d, input logic [15:0] amt, input logic ar,
                       input int gap, input int stall, input bit poke);
    int waits;
    int lat;
    int k;
    bit stable;
    logic [15:0] held;
    logic [15:0] exp;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (gap) step();
    in_valid  = 1'b1;
    data_in   = d;
    shift_amt = amt;
    arith     = ar;
    waits = 0;
    while (!in_ready && waits < 50) begin
      step();
      waits++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    last_accept_waits = waits;
    exp_q.push_back(ref_shift(d, amt, ar));
    k = clamp_amt(amt);
    step();
    // Junk on the input side while busy must be ignored.
    lat = 0;
    in_valid  = 1'($urandom_range(0, 1));
    data_in   = 16'($urandom);
    shift_amt = 16'($urandom);
    arith     = 1'($urandom_range(0, 1));
    while (!out_valid && lat < 40) begin
      step();
      lat++;
      in_valid = 1'($urandom_range(0, 1));
      data_in  = 16'($urandom);
    end
    check_eq("latency", 32'(lat), 32'(k));
    exp = exp_q.pop_front();
    check_eq("result", 32'(data_out), 32'(exp));
    check_eq("in_ready_done", 32'(in_ready), 32'd0);
    check_eq("busy_done", 32'(busy), 32'd1);
    held = data_out;
    stable = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        data_in  = 16'hAAAA;
        shift_amt = 16'd0;
        arith = 1'b0;
      end
      step();
      if (!out_valid || data_out !== held || in_ready) stable = 1'b0;
    end
    if (stall > 0) check_eq("stall_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("post_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_data_out", 32'(data_out), 32'd0);
    if (!poke) in_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit pulsed;
    checks = 0;
    errors = 0;
    last_accept_waits = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    data_in = 16'h0;
    shift_amt = 16'h0;
    arith = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data_out", 32'(data_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    do_op(16'h8000, 16'd1,  1'b0, 0, 0, 1'b0);
    do_op(16'h8000, 16'd4,  1'b1, 1, 0, 1'b0);
    do_op(16'h8000, 16'd4,  1'b0, 0, 2, 1'b0);
    do_op(16'h1234, 16'd0,  1'b0, 0, 0, 1'b0);
    do_op(16'hFFFF, 16'd20, 1'b0, 0, 0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 1'b0);
    do_op(16'h8001, 16'd20, 1'b1, 0, 0, 1'b0);
    do_op(16'h7FFF, 16'd20, 1'b1, 0, 0, 1'b0);
    do_op(16'h8001, 16'd16, 1'b1, 0, 0, 1'b0);
    do_op(16'hC3A5, 16'd15, 1'b1, 0, 1, 1'b0);

    // Backpressure with a competing operand held during the stall; it may
    // only be taken on the first edge after the handshake.
    do_op(16'h1357, 16'd3, 1'b0, 0, 5, 1'b1);
    do_op(16'hAAAA, 16'd0, 1'b0, 0, 0, 1'b1);
    check_eq("stall_next_accept_waits", 32'(last_accept_waits), 32'd0);
    in_valid = 1'b0;
    step();

    // Reset in the third SHIFT cycle
    in_valid = 1'b1;
    data_in = 16'hF0F0;
    shift_amt = 16'd10;
    arith = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check_eq("abort_in_ready_rst", 32'(in_ready), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    pulsed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid || data_out != 16'h0) pulsed = 1'b1;
      step();
    end
    check_eq("abort_no_out", 32'(pulsed), 32'd0);
    do_op(16'h0F00, 16'd8, 1'b0, 0, 0, 1'b0);

    // Randomized operations
    for (int n = 0; n < 200; n++) begin
      logic [15:0] d;
      logic [15:0] a;
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0: a = 16'($urandom);
        1: a = 16'($urandom_range(14, 18));
        default: a = 16'($urandom_range(0, 15));
      endcase
      do_op(d, a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
